issue_sequencer: RTL and testbench

Per-cycle issue controller for the 2-way superscalar ID stage. It consumes the `rollback` code from the hazard detection unit, the EX-stage branch-mispredict signal and the memory-busy signal. From these it drives per-way issue valids, IF/ID and ID/EX load enables, and the fetch redirect. It also tracks the post-redirect fetch-drain window and keeps saturating stall/replay performance counters. It sits between the detection unit and the IF/ID and ID/EX pipeline registers.

---
 rtl/issue_sequencer_pkg.sv | 14 +
 rtl/issue_sequencer_sat_counter.sv | 20 ++
 rtl/issue_sequencer.sv | 117 +++++++++++
 tb/tb_issue_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/issue_sequencer_pkg.sv
// Shared definitions for the ID-stage issue sequencer: rollback codes
// from the hazard detection unit and the sequencer state encoding.
package sys_defs;

  localparam logic [1:0] ROLLBACK_NONE = 2'd0;
  localparam logic [1:0] ROLLBACK_WAY1 = 2'd1;
  localparam logic [1:0] ROLLBACK_BOTH = 2'd2;

  typedef enum logic {
    IS_RUN,
    IS_DRAIN
  } ISSUE_STATE;

endpackage

// File: rtl/issue_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/issue_sequencer.sv
// Per-cycle issue controller for the 2-way ID stage: turns hazard rollback,
// EX mispredict and memory back-pressure into issue valids, register load
// enables and fetch redirects, and tracks the post-redirect drain window.
//
// Handshake: there is no valid/ready pair here; every output is a pure
// function of the current inputs, state and drain_left, valid in the same
// cycle, and the pipeline registers act on them at the next rising clock.
module issue_sequencer
  import sys_defs::*;
#(
  parameter int FETCH_LAT = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       id_valid,
  input  logic [31:0]      id_pc_1,
  input  logic [1:0]       rollback,
  input  logic             ex_mispredict,
  input  logic [31:0]      ex_target,
  input  logic             mem_busy,
  output logic [1:0]       issue_valid,
  output logic             if_id_enable,
  output logic             id_ex_enable,
  output logic             flush_ex,
  output logic             pc_redirect,
  output logic [31:0]      redirect_pc,
  output logic             draining,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] replay_cnt
);

  localparam logic [1:0] DRAIN_LOAD = 2'(FETCH_LAT);

  ISSUE_STATE state, state_next;
  logic [1:0] drain_left, drain_next;
  logic       stall_inc, replay_inc;
  logic       replay_hit, stall_hit;

  // Hazard codes only take effect when the instructions they refer to exist.
  assign replay_hit = (rollback == ROLLBACK_WAY1) && (id_valid == 2'b11);
  assign stall_hit  = rollback[1] && id_valid[0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IS_RUN;
      drain_left <= 2'd0;
    end else begin
      state      <= state_next;
      drain_left <= drain_next;
    end
  end

  always_comb begin
    issue_valid  = 2'b00;
    if_id_enable = 1'b1;
    id_ex_enable = 1'b1;
    flush_ex     = 1'b0;
    pc_redirect  = 1'b0;
    redirect_pc  = ex_target;
    state_next   = state;
    drain_next   = drain_left;
    stall_inc    = 1'b0;
    replay_inc   = 1'b0;

    if (!reset) begin
      state_next = IS_RUN;
      drain_next = 2'd0;
    end else if (mem_busy) begin
      // Full freeze: EX keeps its packet, so a pending mispredict reappears.
      if_id_enable = 1'b0;
      id_ex_enable = 1'b0;
      stall_inc    = 1'b1;
    end else if (ex_mispredict) begin
      flush_ex    = 1'b1;
      pc_redirect = 1'b1;
      redirect_pc = ex_target;
      state_next  = IS_DRAIN;
      drain_next  = DRAIN_LOAD;
    end else if (state == IS_DRAIN) begin
      drain_next = drain_left - 2'd1;
      if (drain_left <= 2'd1) begin
        state_next = IS_RUN;
      end
    end else if (replay_hit) begin
      // Way 0 goes ahead; way 1 is refetched and returns as way 0.
      issue_valid = 2'b01;
      pc_redirect = 1'b1;
      redirect_pc = id_pc_1;
      replay_inc  = 1'b1;
      state_next  = IS_DRAIN;
      drain_next  = DRAIN_LOAD;
    end else if (stall_hit) begin
      if_id_enable = 1'b0;
      stall_inc    = 1'b1;
    end else begin
      issue_valid = id_valid;
    end
  end

  assign draining = (state == IS_DRAIN);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .clear (!reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_replay_cnt (
    .clock (clock),
    .clear (!reset),
    .inc   (replay_inc),
    .count (replay_cnt)
  );

endmodule

// File: tb/tb_issue_sequencer.sv
// Directed bench for issue_sequencer: each cycle's expected outputs are
// queued by the driver and checked by an independent negedge monitor.
module tb_issue_sequencer;

  localparam int W = 47;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  id_valid;
  logic [31:0] id_pc_1;
  logic [1:0]  rollback;
  logic        ex_mispredict;
  logic [31:0] ex_target;
  logic        mem_busy;
  logic [1:0]  issue_valid;
  logic        if_id_enable;
  logic        id_ex_enable;
  logic        flush_ex;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        draining;
  logic [3:0]  stall_cnt;
  logic [3:0]  replay_cnt;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           errors = 0;

  issue_sequencer #(.FETCH_LAT(1), .CNT_W(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_pc_1       (id_pc_1),
    .rollback      (rollback),
    .ex_mispredict (ex_mispredict),
    .ex_target     (ex_target),
    .mem_busy      (mem_busy),
    .issue_valid   (issue_valid),
    .if_id_enable  (if_id_enable),
    .id_ex_enable  (id_ex_enable),
    .flush_ex      (flush_ex),
    .pc_redirect   (pc_redirect),
    .redirect_pc   (redirect_pc),
    .draining      (draining),
    .stall_cnt     (stall_cnt),
    .replay_cnt    (replay_cnt)
  );

  // clock / reset
  always #5 clock = ~clock;

  // Layout: iv[46:45] ifid[44] idex[43] flush[42] redir[41] pc[40:9] drain[8] stall[7:4] replay[3:0]
  function automatic logic [W-1:0] pack(input logic [1:0] iv, input logic ifid, input logic idex,
                                        input logic fl, input logic rd, input logic [31:0] rpc,
                                        input logic dr, input logic [3:0] st, input logic [3:0] rp);
    return {iv, ifid, idex, fl, rd, rpc, dr, st, rp};
  endfunction

  // monitor / scoreboard
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      logic [W-1:0] got;
      string        t;
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      got = pack(issue_valid, if_id_enable, id_ex_enable, flush_ex, pc_redirect, redirect_pc,
                 draining, stall_cnt, replay_cnt);
      if (!e[41]) got[40:9] = e[40:9];
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got iv=%b ifid=%b idex=%b fl=%b rd=%b pc=%h dr=%b st=%0d rp=%0d, exp iv=%b ifid=%b idex=%b fl=%b rd=%b pc=%h dr=%b st=%0d rp=%0d",
                 t, got[46:45], got[44], got[43], got[42], got[41], got[40:9], got[8], got[7:4], got[3:0],
                 e[46:45], e[44], e[43], e[42], e[41], e[40:9], e[8], e[7:4], e[3:0]);
      end
    end
  end

  // driver: inputs are already applied; queue the expectation and advance one cycle
  task automatic step(input string tag, input logic [W-1:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    reset         = 1'b1;
    id_valid      = 2'b11;
    id_pc_1       = 32'h0;
    rollback      = 2'd0;
    ex_mispredict = 1'b0;
    ex_target     = 32'h0;
    mem_busy      = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    @(posedge clock);
    #1;

    // reset held, then released
    step("reset_c1", pack(2'b00, 1, 1, 0, 0, 32'h0, 0, 4'd0, 4'd0));
    step("reset_c2", pack(2'b00, 1, 1, 0, 0, 32'h0, 0, 4'd0, 4'd0));
    reset = 1'b1;
    step("post_reset", pack(2'b11, 1, 1, 0, 0, 32'h0, 0, 4'd0, 4'd0));

    // rollback-1 replay
    rollback = 2'd1; id_pc_1 = 32'h104;
    step("replay_issue", pack(2'b01, 1, 1, 0, 1, 32'h104, 0, 4'd0, 4'd0));
    rollback = 2'd0;
    step("replay_drain", pack(2'b00, 1, 1, 0, 0, 32'h0, 1, 4'd0, 4'd1));
    step("replay_run", pack(2'b11, 1, 1, 0, 0, 32'h0, 0, 4'd0, 4'd1));
    rollback = 2'd1; id_valid = 2'b01;
    step("rb1_single_way", pack(2'b01, 1, 1, 0, 0, 32'h0, 0, 4'd0, 4'd1));

    // load-use stalls
    rollback = 2'd2; id_valid = 2'b11;
    step("stall_1", pack(2'b00, 0, 1, 0, 0, 32'h0, 0, 4'd0, 4'd1));
    step("stall_2", pack(2'b00, 0, 1, 0, 0, 32'h0, 0, 4'd1, 4'd1));
    step("stall_3", pack(2'b00, 0, 1, 0, 0, 32'h0, 0, 4'd2, 4'd1));
    rollback = 2'd0;
    step("stall_release", pack(2'b11, 1, 1, 0, 0, 32'h0, 0, 4'd3, 4'd1));
    rollback = 2'd3; id_valid = 2'b10;
    step("rb3_no_way0", pack(2'b10, 1, 1, 0, 0, 32'h0, 0, 4'd3, 4'd1));
    id_valid = 2'b11;
    step("rb3_stall", pack(2'b00, 0, 1, 0, 0, 32'h0, 0, 4'd3, 4'd1));
    rollback = 2'd0;
    step("rb3_release", pack(2'b11, 1, 1, 0, 0, 32'h0, 0, 4'd4, 4'd1));

    // mispredict, then mispredict again inside DRAIN
    ex_mispredict = 1'b1; ex_target = 32'h180;
    step("mispredict_run", pack(2'b00, 1, 1, 1, 1, 32'h180, 0, 4'd4, 4'd1));
    ex_target = 32'h200;
    step("mispredict_drain", pack(2'b00, 1, 1, 1, 1, 32'h200, 1, 4'd4, 4'd1));
    ex_mispredict = 1'b0; rollback = 2'd2;
    step("drain_ignores_rb", pack(2'b00, 1, 1, 0, 0, 32'h0, 1, 4'd4, 4'd1));
    rollback = 2'd0;
    step("drain_done", pack(2'b11, 1, 1, 0, 0, 32'h0, 0, 4'd4, 4'd1));

    // mem_busy masks a mispredict until it drops
    mem_busy = 1'b1; ex_mispredict = 1'b1; ex_target = 32'h300;
    step("busy_mis_1", pack(2'b00, 0, 0, 0, 0, 32'h0, 0, 4'd4, 4'd1));
    step("busy_mis_2", pack(2'b00, 0, 0, 0, 0, 32'h0, 0, 4'd5, 4'd1));
    mem_busy = 1'b0;
    step("busy_drop_mis", pack(2'b00, 1, 1, 1, 1, 32'h300, 0, 4'd6, 4'd1));
    ex_mispredict = 1'b0;
    step("busy_mis_drain", pack(2'b00, 1, 1, 0, 0, 32'h0, 1, 4'd6, 4'd1));
    step("busy_mis_run", pack(2'b11, 1, 1, 0, 0, 32'h0, 0, 4'd6, 4'd1));

    // mem_busy freezes the drain count
    ex_mispredict = 1'b1; ex_target = 32'h3c0;
    step("mis_before_hold", pack(2'b00, 1, 1, 1, 1, 32'h3c0, 0, 4'd6, 4'd1));
    ex_mispredict = 1'b0; mem_busy = 1'b1;
    step("drain_held", pack(2'b00, 0, 0, 0, 0, 32'h0, 1, 4'd6, 4'd1));
    mem_busy = 1'b0;
    step("drain_resume", pack(2'b00, 1, 1, 0, 0, 32'h0, 1, 4'd7, 4'd1));
    step("hold_run", pack(2'b11, 1, 1, 0, 0, 32'h0, 0, 4'd7, 4'd1));

    // reset aborts a drain
    ex_mispredict = 1'b1; ex_target = 32'h400;
    step("mis_before_reset", pack(2'b00, 1, 1, 1, 1, 32'h400, 0, 4'd7, 4'd1));
    ex_mispredict = 1'b0; reset = 1'b0;
    step("reset_in_drain", pack(2'b00, 1, 1, 0, 0, 32'h0, 1, 4'd7, 4'd1));
    reset = 1'b1;
    step("run_after_reset", pack(2'b11, 1, 1, 0, 0, 32'h0, 0, 4'd0, 4'd0));

    // stall counter saturation
    rollback = 2'd2;
    for (int k = 0; k < 18; k++) begin
      step($sformatf("sat_%0d", k),
           pack(2'b00, 0, 1, 0, 0, 32'h0, 0, (k > 15) ? 4'd15 : 4'(k), 4'd0));
    end
    rollback = 2'd0;
    step("sat_hold", pack(2'b11, 1, 1, 0, 0, 32'h0, 0, 4'd15, 4'd0));

    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: got %0d pending, exp 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
